// File: rtl/alt_pkg.sv
// Shared definitions for the get_altitude rocket-flight integrator.
//   phase_e    : flight phase encoding, also driven out on the phase port
//   UsPerS     : microseconds per second, divisor of the Euler displacement term
//   ValueScale : fixed-point scale of altitude and velocity (1e9 per metre, m/s)
`timescale 1ns/1ps
package alt_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StBurn    = 3'd1,
    StCoast   = 3'd2,
    StDescent = 3'd3,
    StLanded  = 3'd4
  } phase_e;

  localparam longint unsigned UsPerS     = 64'd1_000_000;
  localparam longint unsigned ValueScale = 64'd1_000_000_000;

endpackage

// File: rtl/alt_step.sv
// Combinational explicit-Euler step.
//   altitude      : current altitude (signed, 1e9 scale)
//   velocity      : velocity used for the displacement term (signed, 1e9 scale)
//   next_altitude : altitude + velocity*PERIOD/1e6, truncated toward zero
//   next_velocity : velocity - GRAVITY*PERIOD
// Build option ALT_SATURATE_EN: clamp both results to the signed N-bit range
// instead of wrapping.
`timescale 1ns/1ps
module alt_step
  import alt_pkg::*;
#(
  parameter longint unsigned PERIOD  = 10,
  parameter longint unsigned GRAVITY = 9_799,
  parameter int unsigned     N       = 64
) (
  input  logic signed [N-1:0] altitude,
  input  logic signed [N-1:0] velocity,
  output logic signed [N-1:0] next_altitude,
  output logic signed [N-1:0] next_velocity
);

  // Double-width arithmetic so the product and sums never lose bits before
  // the final wrap or clamp.
  localparam int unsigned W = 2 * N;
  localparam logic signed [W-1:0] PeriodW = W'(PERIOD);
  localparam logic signed [W-1:0] UsPerSW = W'(UsPerS);
  localparam logic signed [W-1:0] DeltaVW = W'(GRAVITY * PERIOD);

  logic signed [W-1:0] alt_w, vel_w, delta_alt, alt_sum, vel_sum;

  assign alt_w     = {{N{altitude[N-1]}}, altitude};
  assign vel_w     = {{N{velocity[N-1]}}, velocity};
  // Signed division truncates toward zero.
  assign delta_alt = (vel_w * PeriodW) / UsPerSW;
  assign alt_sum   = alt_w + delta_alt;
  assign vel_sum   = vel_w - DeltaVW;

`ifdef ALT_SATURATE_EN
  function automatic logic signed [N-1:0] clamp(input logic signed [W-1:0] v);
    // In range when all bits above the N-bit sign bit copy it.
    if ((v[W-1:N-1] == '0) || (v[W-1:N-1] == '1)) return v[N-1:0];
    else if (v[W-1])                                return {1'b1, {(N-1){1'b0}}};
    else                                            return {1'b0, {(N-1){1'b1}}};
  endfunction

  assign next_altitude = clamp(alt_sum);
  assign next_velocity = clamp(vel_sum);
`else
  logic unused_hi;
  assign unused_hi     = ^{alt_sum[W-1:N], vel_sum[W-1:N]};
  assign next_altitude = alt_sum[N-1:0];
  assign next_velocity = vel_sum[N-1:0];
`endif

endmodule

// File: rtl/get_altitude.sv
// Rocket flight integrator: BURN follows streamed velocity samples, COAST and
// DESCENT free-fall under gravity, apogee captured at the velocity sign change.
//   clk, resetb       : step clock, asynchronous active-low reset
//   start, burntime   : launch request (accepted in IDLE/LANDED), burn length in us
//   vel_in, vel_valid : burn-phase velocity stream; vel_ready high in BURN
//   altitude          : registered altitude (signed, 1e9 scale)
//   cur_velocity      : registered velocity (signed, 1e9 scale)
//   phase             : IDLE=0 BURN=1 COAST=2 DESCENT=3 LANDED=4
//   apogee(_valid)    : captured peak altitude
//   done              : high in LANDED
// Build option ALT_SATURATE_EN: altitude/velocity clamp rather than wrap.
`timescale 1ns/1ps
module get_altitude
  import alt_pkg::*;
#(
  parameter longint unsigned PERIOD  = 10,
  parameter longint unsigned GRAVITY = 9_799,
  parameter int unsigned     N       = 64
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                start,
  input  logic [N-1:0]        burntime,
  input  logic signed [N-1:0] vel_in,
  input  logic                vel_valid,
  output logic                vel_ready,
  output logic signed [N-1:0] altitude,
  output logic signed [N-1:0] cur_velocity,
  output logic [2:0]          phase,
  output logic signed [N-1:0] apogee,
  output logic                apogee_valid,
  output logic                done
);

  localparam logic signed [N-1:0] Zero = '0;

  phase_e              state_q, state_d;
  logic signed [N-1:0] alt_q, alt_d, vel_q, vel_d, apogee_q, apogee_d;
  logic [N-1:0]        elapsed_q, elapsed_d, burn_q, burn_d;
  logic                apv_q, apv_d;
  logic signed [N-1:0] step_vel_in, step_alt, step_vel;

  // During BURN the displacement uses the incoming sample, not the old velocity.
  assign step_vel_in = (state_q == StBurn) ? vel_in : vel_q;

  alt_step #(
    .PERIOD (PERIOD),
    .GRAVITY(GRAVITY),
    .N      (N)
  ) u_step (
    .altitude     (alt_q),
    .velocity     (step_vel_in),
    .next_altitude(step_alt),
    .next_velocity(step_vel)
  );

  always_comb begin
    state_d   = state_q;
    alt_d     = alt_q;
    vel_d     = vel_q;
    apogee_d  = apogee_q;
    apv_d     = apv_q;
    elapsed_d = elapsed_q;
    burn_d    = burn_q;
    case (state_q)
      StIdle, StLanded: begin
        if (start) begin
          alt_d     = '0;
          vel_d     = '0;
          apogee_d  = '0;
          apv_d     = 1'b0;
          elapsed_d = '0;
          burn_d    = burntime;
          state_d   = (burntime == '0) ? StCoast : StBurn;
        end
      end
      StBurn: begin
        if (vel_valid) begin
          vel_d     = vel_in;
          alt_d     = step_alt;
          elapsed_d = elapsed_q + N'(PERIOD);
          if (elapsed_d >= burn_q) state_d = StCoast;
        end
      end
      StCoast: begin
        alt_d = step_alt;
        vel_d = step_vel;
        if (step_vel <= Zero) begin
          apogee_d = step_alt;
          apv_d    = 1'b1;
          state_d  = StDescent;
        end
      end
      StDescent: begin
        alt_d = step_alt;
        vel_d = step_vel;
        if (step_alt <= Zero) begin
          alt_d   = '0;
          state_d = StLanded;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= StIdle;
      alt_q     <= '0;
      vel_q     <= '0;
      apogee_q  <= '0;
      apv_q     <= 1'b0;
      elapsed_q <= '0;
      burn_q    <= '0;
    end else begin
      state_q   <= state_d;
      alt_q     <= alt_d;
      vel_q     <= vel_d;
      apogee_q  <= apogee_d;
      apv_q     <= apv_d;
      elapsed_q <= elapsed_d;
      burn_q    <= burn_d;
    end
  end

  assign vel_ready    = (state_q == StBurn);
  assign done         = (state_q == StLanded);
  assign phase        = state_q;
  assign altitude     = alt_q;
  assign cur_velocity = vel_q;
  assign apogee       = apogee_q;
  assign apogee_valid = apv_q;

endmodule
